// File: rtl/fir_pkg.sv
// Shared constants and helpers for the parameterised FIR filter.
// Provides accumulator sizing, pipeline latency and output saturation.
package fir_pkg;

    localparam int FIR_LATENCY = 3;
    localparam int SAT_W       = 256;

    function automatic int tree_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    function automatic int acc_width(
        input int wl,
        input int cwl,
        input int ntaps
    );
        return tree_width(wl + cwl, ntaps);
    endfunction

    // Clamp a wide signed value into the signed range of wl bits.
    function automatic logic signed [SAT_W-1:0] fir_sat(
        input logic signed [SAT_W-1:0] v,
        input int                      wl
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = ({{(SAT_W-1){1'b0}}, 1'b1} << (wl - 1))
             - {{(SAT_W-1){1'b0}}, 1'b1};
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered reduction of N signed operands of width W.
// Output width grows by clog2(N) so the sum never overflows.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 48,
    parameter int OW = tree_width(W, N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic [N*W-1:0] i_ops,
    output logic [OW-1:0]  o_sum
);

    logic signed [OW-1:0] w_acc;

    // Sign-extend every operand and add them all.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            w_acc = w_acc + OW'($signed(i_ops[i*W +: W]));
        end
    end

    // Sum register; holds its value when no product is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sum <= '0;
        end else if (i_en) begin
            o_sum <= w_acc;
        end
    end

endmodule

// File: rtl/param_fir.sv
// Three-stage pipelined FIR: delay line, products, sum/output.
// Define FIR_SAT_EN to saturate the output instead of wrapping.
module param_fir
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int WL    = 32,
    parameter int CWL   = 16,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WL-1:0]            xin,
    input  logic                     coef_wr,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [CWL-1:0]           coef_data,
    output logic                     out_valid,
    output logic [WL-1:0]            yout
);

    localparam int AW = $clog2(NTAPS);
    localparam int PW = WL + CWL;
    localparam int SW = acc_width(WL, CWL, NTAPS);

    logic signed [WL-1:0]   r_x [NTAPS];
    logic signed [CWL-1:0]  r_h [NTAPS];
    logic [NTAPS*PW-1:0]    r_p;
    logic [FIR_LATENCY-1:0] r_vld;
    logic                   r_cw_v;
    logic [AW-1:0]          r_cw_addr;
    logic [CWL-1:0]         r_cw_data;
    logic signed [SW-1:0]   w_sum;
    logic signed [SW-1:0]   w_shift;
    logic                   w_unused;

    // Delay line: shift in a sample on accept, zero on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
        end else if (in_valid) begin
            r_x[0] <= $signed(xin);
            for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
        end
    end

    // Valid pipeline tracking each accepted sample to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (clr) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[FIR_LATENCY-2:0], in_valid};
        end
    end

    // Coefficient writes land one edge late so a sample accepted
    // alongside a write still multiplies by the old tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw_v    <= 1'b0;
            r_cw_addr <= '0;
            r_cw_data <= '0;
        end else begin
            r_cw_v    <= coef_wr && (int'(coef_addr) < NTAPS);
            r_cw_addr <= coef_addr;
            r_cw_data <= coef_data;
        end
    end

    // Coefficient bank, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) r_h[k] <= '0;
        end else if (r_cw_v) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (r_cw_addr == AW'(k)) begin
                    r_h[k] <= $signed(r_cw_data);
                end
            end
        end
    end

    // Full-width products of each tap with its coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
        end else if (r_vld[0]) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_p[k*PW +: PW] <= PW'(r_x[k]) * PW'(r_h[k]);
            end
        end
    end

    fir_adder_tree #(
        .N  (NTAPS),
        .W  (PW),
        .OW (SW)
    ) u_tree (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_vld[1]),
        .i_ops (r_p),
        .o_sum (w_sum)
    );

    assign w_shift   = w_sum >>> SHIFT;
    assign out_valid = r_vld[FIR_LATENCY-1];

`ifdef FIR_SAT_EN
    logic signed [SAT_W-1:0] w_sat;
    assign w_sat    = fir_sat(SAT_W'(w_shift), WL);
    assign yout     = w_sat[WL-1:0];
    assign w_unused = ^w_sat[SAT_W-1:WL];
`else
    assign yout     = w_shift[WL-1:0];
    assign w_unused = ^w_shift[SW-1:WL];
`endif

endmodule

// File: tb/tb_param_fir.sv
// Scoreboard bench for param_fir: three parameter sets, directed
// and random stimulus against a sum-of-products reference model.
module tb_param_fir;

    localparam int NT_A = 3, WL_A = 32, CW_A = 16, SH_A = 0;
    localparam int NT_B = 4, WL_B = 8,  CW_B = 8,  SH_B = 0;
    localparam int NT_C = 5, WL_C = 12, CW_C = 6,  SH_C = 3;
`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint y;
        int     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        coef_wr = 1'b0;
    logic [31:0] xin = '0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        ov_a, ov_b, ov_c;
    logic [31:0] y_a;
    logic [7:0]  y_b;
    logic [11:0] y_c;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    exp_t   qa[$], qb[$], qc[$];
    longint loga[$], logb[$];
    longint hist[$];
    longint h [3][64];
    int nt [3] = '{NT_A, NT_B, NT_C};
    int wl [3] = '{WL_A, WL_B, WL_C};
    int cw [3] = '{CW_A, CW_B, CW_C};
    int sh [3] = '{SH_A, SH_B, SH_C};
    int aw [3] = '{2, 2, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_fir #(.NTAPS(NT_A), .WL(WL_A), .CWL(CW_A), .SHIFT(SH_A)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .xin(xin), .coef_wr(coef_wr), .coef_addr(coef_addr[1:0]),
        .coef_data(coef_data), .out_valid(ov_a), .yout(y_a));

    param_fir #(.NTAPS(NT_B), .WL(WL_B), .CWL(CW_B), .SHIFT(SH_B)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .xin(xin[7:0]), .coef_wr(coef_wr), .coef_addr(coef_addr[1:0]),
        .coef_data(coef_data[7:0]), .out_valid(ov_b), .yout(y_b));

    param_fir #(.NTAPS(NT_C), .WL(WL_C), .CWL(CW_C), .SHIFT(SH_C)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .xin(xin[11:0]), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_data(coef_data[5:0]), .out_valid(ov_c), .yout(y_c));

    function automatic longint sx(longint v, int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // y = sum h[k]*x[n-k], floor-shift, then clamp or wrap to WL.
    function automatic longint model_y(int d);
        longint s = 0;
        longint lim;
        for (int k = 0; k < nt[d]; k++) begin
            if (k < hist.size()) s += h[d][k] * sx(hist[k], wl[d]);
        end
        s = s >>> sh[d];
        lim = (longint'(1) <<< (wl[d] - 1)) - 1;
        if (SAT) begin
            if (s > lim) s = lim;
            else if (s < -lim - 1) s = -lim - 1;
            return s;
        end
        return sx(s, wl[d]);
    endfunction

    function automatic void check_eq(string nm, logic signed [63:0] got,
                                     longint want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endfunction

    function automatic void push(int d, longint y, int c);
        exp_t e;
        e.y = y;
        e.cyc = c;
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endfunction

    function automatic void trim(int c);
        while (qa.size() > 0 && qa[$].cyc > c) void'(qa.pop_back());
        while (qb.size() > 0 && qb[$].cyc > c) void'(qb.pop_back());
        while (qc.size() > 0 && qc[$].cyc > c) void'(qc.pop_back());
    endfunction

    task automatic step(input bit iv, input longint x, input bit wr = 0,
                        input int a = 0, input longint dta = 0,
                        input bit c = 0);
        in_valid  = iv;
        xin       = 32'(x);
        coef_wr   = wr;
        coef_addr = 3'(a);
        coef_data = 16'(dta);
        clr       = c;
        if (c) begin
            hist.delete();
            trim(cyc);
        end else if (iv) begin
            hist.push_front(sx(x, 32));
            if (hist.size() > 64) void'(hist.pop_back());
            for (int d = 0; d < 3; d++) push(d, model_y(d), cyc + 3);
        end
        if (wr) begin
            for (int d = 0; d < 3; d++) begin
                int ad;
                ad = a & ((1 << aw[d]) - 1);
                if (ad < nt[d]) h[d][ad] = sx(dta, cw[d]);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        clr      = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        hist.delete();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 64; k++) h[d][k] = 0;
        #1;
        check_eq("rst_ov_a", ov_a, 0);
        check_eq("rst_ov_b", ov_b, 0);
        check_eq("rst_ov_c", ov_c, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_y_a", y_a, 0);
        check_eq("rst_y_b", y_b, 0);
        check_eq("rst_y_c", y_c, 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov_a !== 1'b0) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL valid_a: out_valid=%b at cycle %0d, none due",
                         ov_a, cyc);
            end else begin
                e = qa.pop_front();
                loga.push_back(longint'($signed(y_a)));
                if (y_a !== 32'(e.y) || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_a: got %0d @%0d, expected %0d @%0d",
                             $signed(y_a), cyc, e.y, e.cyc);
                end
            end
        end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            n_chk++;
            n_fail++;
            e = qa.pop_front();
            $display("FAIL miss_a: out_valid=0 at %0d, expected %0d @%0d",
                     cyc, e.y, e.cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov_b !== 1'b0) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL valid_b: out_valid=%b at cycle %0d, none due",
                         ov_b, cyc);
            end else begin
                e = qb.pop_front();
                logb.push_back(longint'($signed(y_b)));
                if (y_b !== 8'(e.y) || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_b: got %0d @%0d, expected %0d @%0d",
                             $signed(y_b), cyc, e.y, e.cyc);
                end
            end
        end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            n_chk++;
            n_fail++;
            e = qb.pop_front();
            $display("FAIL miss_b: out_valid=0 at %0d, expected %0d @%0d",
                     cyc, e.y, e.cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov_c !== 1'b0) begin
            n_chk++;
            if (qc.size() == 0) begin
                n_fail++;
                $display("FAIL valid_c: out_valid=%b at cycle %0d, none due",
                         ov_c, cyc);
            end else begin
                e = qc.pop_front();
                if (y_c !== 12'(e.y) || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_c: got %0d @%0d, expected %0d @%0d",
                             $signed(y_c), cyc, e.y, e.cyc);
                end
            end
        end else if (qc.size() > 0 && qc[0].cyc <= cyc) begin
            n_chk++;
            n_fail++;
            e = qc.pop_front();
            $display("FAIL miss_c: out_valid=0 at %0d, expected %0d @%0d",
                     cyc, e.y, e.cyc);
        end
    end

    function automatic longint la(int i);
        return (i < loga.size()) ? loga[i] : 64'sd999999;
    endfunction

    longint e_imp[4]  = '{-3, 3, 5, 0};
    longint e_step[4] = '{-30, 0, 50, 50};
    longint e_gap[3]  = '{-3, 3, 5};
    longint e_rew[3]  = '{-3, 0, 9};

    initial begin
        do_reset();

        step(0, 0, 1, 0, -3);
        step(0, 0, 1, 1, 3);
        step(0, 0, 1, 2, 5);

        loga.delete();
        step(1, 1);
        for (int i = 0; i < 3; i++) step(1, 0);
        idle(5);
        for (int i = 0; i < 4; i++) check_eq("impulse", la(i), e_imp[i]);

        step(0, 0, 0, 0, 0, 1);
        loga.delete();
        for (int i = 0; i < 4; i++) step(1, 10);
        idle(5);
        for (int i = 0; i < 4; i++) check_eq("step10", la(i), e_step[i]);

        step(0, 0, 0, 0, 0, 1);
        loga.delete();
        step(1, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(1, 0);
        idle(5);
        for (int i = 0; i < 3; i++) check_eq("gapped", la(i), e_gap[i]);
        check_eq("gapped_count", loga.size(), 3);

        step(0, 0, 0, 0, 0, 1);
        loga.delete();
        step(1, 1);
        step(1, 1, 1, 1, 7);
        step(1, 1);
        idle(5);
        for (int i = 0; i < 3; i++) check_eq("rewrite_h1", la(i), e_rew[i]);

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 127);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 2, 0);
        step(0, 0, 1, 3, 0);
        logb.delete();
        step(1, 127);
        idle(5);
        check_eq("sat_wrap_b", (logb.size() > 0) ? logb[0] : 64'sd999,
                 SAT ? 64'sd127 : 64'sd1);

        step(1, 5);
        step(1, 6);
        step(1, 7);
        step(0, 0, 0, 0, 0, 1);
        check_eq("clr_ov_a", ov_a, 0);
        check_eq("clr_ov_b", ov_b, 0);
        idle(4);

        step(1, 5);
        step(1, 6);
        step(1, 7);
        do_reset();
        loga.delete();
        for (int i = 0; i < 3; i++) step(1, 1);
        idle(5);
        for (int i = 0; i < 3; i++) check_eq("zero_coef", la(i), 0);

        for (int k = 0; k < 8; k++)
            step(0, 0, 1, k, longint'($urandom_range(0, 65535)));
        for (int i = 0; i < 600; i++) begin
            bit iv;
            bit wr;
            bit c;
            iv = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 59) == 0);
            if (i == 300) do_reset();
            step(iv, longint'($signed($urandom)), wr,
                 int'($urandom_range(0, 7)),
                 longint'($urandom_range(0, 65535)), c);
        end
        idle(6);
        check_eq("drain_a", qa.size(), 0);
        check_eq("drain_b", qb.size(), 0);
        check_eq("drain_c", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
